// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared encodings, field widths and moduli for the time counter
package time_pkg;

  typedef enum logic [1:0] {
    MODE_SW    = 2'b00,
    MODE_TMR   = 2'b01,
    MODE_WATCH = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FSEL_SEC  = 2'd0,
    FSEL_MIN  = 2'd1,
    FSEL_HOUR = 2'd2,
    FSEL_NONE = 2'd3
  } fsel_e;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int MSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;

  // Fields are zero-extended to 7 bits so one pair of helpers serves all moduli.
  function automatic logic [6:0] mod_inc(input logic [6:0] v, input logic [6:0] max);
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] mod_dec(input logic [6:0] v, input logic [6:0] max);
    return (v == 7'd0) ? max : v - 7'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one base tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Parked at zero while disabled so a restart always sees a full period.
  always_ff @(posedge clk) begin
    if (rst || sync_clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/time_count_core.sv
// rtl/time_count_core.sv - stopwatch / countdown / watch time-keeping core
module time_count_core
  import time_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MOD = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              run_toggle,
  input  logic              clear,
  input  logic              lap,
  input  logic              inc,
  input  logic              dec,
  input  logic [1:0]        field_sel,
  output logic [MSEC_W-1:0] msec_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [HOUR_W-1:0] hour_o,
  output logic              running,
  output logic              lap_active,
  output logic              done,
  output logic              tick_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [6:0] MSEC_MAX = 7'(MSEC_MOD - 1);
  localparam logic [6:0] SEC_MAX  = 7'(SEC_MOD - 1);
  localparam logic [6:0] MIN_MAX  = 7'(MIN_MOD - 1);
  localparam logic [6:0] HOUR_MAX = 7'(HOUR_MOD - 1);

  logic [MSEC_W-1:0] msec_q, snap_msec, up_msec, dn_msec;
  logic [SEC_W-1:0]  sec_q,  snap_sec,  up_sec,  dn_sec;
  logic [MIN_W-1:0]  min_q,  snap_min,  up_min,  dn_min;
  logic [HOUR_W-1:0] hour_q, snap_hour, up_hour, dn_hour;
  logic [1:0]        prev_mode;
  logic              run_ff, lap_q, done_q, tick;
  logic              is_sw, is_tmr, is_watch, mode_chg, clr_eff, all_zero;
  logic              run_tgl_eff, adj_ok, dn_zero;
  logic              c_ms, c_s, c_m, b_ms, b_s, b_m;

  // Behaviour follows the registered mode; a differing input is handled as a mode change first.
  always_comb begin
    is_tmr      = (prev_mode == MODE_TMR);
    is_watch    = (prev_mode == MODE_WATCH);
    is_sw       = !is_tmr && !is_watch;
    mode_chg    = (mode != prev_mode);
    clr_eff     = clear && !is_watch;
    all_zero    = (msec_q == '0) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);
    run_tgl_eff = run_toggle && !is_watch && !(is_tmr && all_zero);
    adj_ok      = (inc ^ dec) && (field_sel != FSEL_NONE) && (is_watch || (is_tmr && !run_ff));
  end

  always_comb begin
    c_ms    = (msec_q == MSEC_MAX);
    c_s     = c_ms && (7'(sec_q) == SEC_MAX);
    c_m     = c_s && (7'(min_q) == MIN_MAX);
    up_msec = mod_inc(msec_q, MSEC_MAX);
    up_sec  = c_ms ? SEC_W'(mod_inc(7'(sec_q), SEC_MAX)) : sec_q;
    up_min  = c_s ? MIN_W'(mod_inc(7'(min_q), MIN_MAX)) : min_q;
    up_hour = c_m ? HOUR_W'(mod_inc(7'(hour_q), HOUR_MAX)) : hour_q;

    b_ms    = (msec_q == '0);
    b_s     = b_ms && (sec_q == '0);
    b_m     = b_s && (min_q == '0);
    dn_msec = mod_dec(msec_q, MSEC_MAX);
    dn_sec  = b_ms ? SEC_W'(mod_dec(7'(sec_q), SEC_MAX)) : sec_q;
    dn_min  = b_s ? MIN_W'(mod_dec(7'(min_q), MIN_MAX)) : min_q;
    dn_hour = b_m ? HOUR_W'(mod_dec(7'(hour_q), HOUR_MAX)) : hour_q;
    dn_zero = (dn_msec == '0) && (dn_sec == '0) && (dn_min == '0) && (dn_hour == '0);
  end

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (run_ff || is_watch),
    .sync_clr (mode_chg || clr_eff),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (rst) begin
      msec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      run_ff    <= 1'b0;
      lap_q     <= 1'b0;
      prev_mode <= MODE_SW;
    end else if (mode_chg) begin
      run_ff    <= 1'b0;
      lap_q     <= 1'b0;
      prev_mode <= mode;
    end else if (clr_eff) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      run_ff <= 1'b0;
      lap_q  <= 1'b0;
    end else begin
      if (lap && is_sw) begin
        lap_q <= !lap_q;
        if (!lap_q) begin
          snap_msec <= msec_q;
          snap_sec  <= sec_q;
          snap_min  <= min_q;
          snap_hour <= hour_q;
        end
      end
      // An accepted adjust swallows a coincident tick's count step.
      if (run_tgl_eff) begin
        run_ff <= !run_ff;
      end else if (adj_ok) begin
        case (field_sel)
          FSEL_SEC: begin
            sec_q  <= inc ? SEC_W'(mod_inc(7'(sec_q), SEC_MAX)) : SEC_W'(mod_dec(7'(sec_q), SEC_MAX));
            msec_q <= '0;
          end
          FSEL_MIN:  min_q  <= inc ? MIN_W'(mod_inc(7'(min_q), MIN_MAX)) : MIN_W'(mod_dec(7'(min_q), MIN_MAX));
          FSEL_HOUR: hour_q <= inc ? HOUR_W'(mod_inc(7'(hour_q), HOUR_MAX)) : HOUR_W'(mod_dec(7'(hour_q), HOUR_MAX));
          default: ;
        endcase
      end else if (tick) begin
        if (is_tmr) begin
          msec_q <= dn_msec;
          sec_q  <= dn_sec;
          min_q  <= dn_min;
          hour_q <= dn_hour;
          if (dn_zero) begin
            done_q <= 1'b1;
            run_ff <= 1'b0;
          end
        end else begin
          msec_q <= up_msec;
          sec_q  <= up_sec;
          min_q  <= up_min;
          hour_q <= up_hour;
        end
      end
    end
  end

  assign msec_o     = lap_q ? snap_msec : msec_q;
  assign sec_o      = lap_q ? snap_sec  : sec_q;
  assign min_o      = lap_q ? snap_min  : min_q;
  assign hour_o     = lap_q ? snap_hour : hour_q;
  assign running    = run_ff || is_watch;
  assign lap_active = lap_q;
  assign done       = done_q;
  assign tick_o     = tick;

endmodule

// File: tb/tb_time_count_core.sv
// tb/tb_time_count_core.sv - scoreboard bench for time_count_core at DIV = 10
module tb_time_count_core;

  localparam int DIV = 10;
  localparam int P_RUN = 0, P_CLR = 1, P_LAP = 2, P_RUNCLR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [1:0] field_sel = 2'd3;
  logic       run_toggle = 1'b0, clear = 1'b0, lap = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [6:0] msec_o;
  logic [5:0] sec_o, min_o;
  logic [4:0] hour_o;
  logic       running, lap_active, done, tick_o;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ticks_seen = 0;
  int   dones_seen = 0;

  always #5 clk = ~clk;

  time_count_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .run_toggle (run_toggle),
    .clear      (clear),
    .lap        (lap),
    .inc        (inc),
    .dec        (dec),
    .field_sel  (field_sel),
    .msec_o     (msec_o),
    .sec_o      (sec_o),
    .min_o      (min_o),
    .hour_o     (hour_o),
    .running    (running),
    .lap_active (lap_active),
    .done       (done),
    .tick_o     (tick_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int h, input int m, input int s, input int ms,
                                     input int r, input int l, input int d);
    return {5'b0, 5'(h), 6'(m), 6'(s), 7'(ms), 1'(r), 1'(l), 1'(d)};
  endfunction

  task automatic push(input string tag, input int h, input int m, input int s, input int ms,
                      input int r, input int l, input int d);
    exp_t e;
    e.tag = tag;
    e.exp = pk(h, m, s, ms, r, l, d);
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, pk(32'(hour_o), 32'(min_o), 32'(sec_o), 32'(msec_o),
                      32'(running), 32'(lap_active), 32'(done)), e.exp);
    end
  endtask

  // The bench always stands on a falling edge; step moves to the next one.
  task automatic step();
    @(negedge clk);
    if (tick_o) ticks_seen++;
    if (done) dones_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int which);
    case (which)
      P_RUN:    run_toggle = 1'b1;
      P_CLR:    clear = 1'b1;
      P_LAP:    lap = 1'b1;
      default: begin
        run_toggle = 1'b1;
        clear = 1'b1;
      end
    endcase
    step();
    run_toggle = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
  endtask

  task automatic adjust(input logic [1:0] sel, input logic i, input logic d);
    field_sel = sel;
    inc = i;
    dec = d;
    step();
    inc = 1'b0;
    dec = 1'b0;
    field_sel = 2'd3;
  endtask

  // Counts tick_o pulses including the current cycle, then steps past the last one.
  task automatic wait_ticks(input int n);
    int got = 0;
    int budget = n * DIV + 40;
    forever begin
      if (tick_o) got++;
      if (got == n || budget == 0) break;
      step();
      budget--;
    end
    check("ticks", 32'(got), 32'(n));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int w;
    idle(2);
    push("reset", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();
    check("reset_tick", 32'(tick_o), 32'd0);
    rst = 1'b0;
    step();

    // stopwatch count and hold
    pulse(P_RUN);
    push("sw_start", 0, 0, 0, 0, 1, 0, 0);
    pop_cmp();
    lat = 0;
    while (!tick_o && lat < 5 * DIV) begin
      step();
      lat++;
    end
    check("first_tick_lat", 32'(lat), 32'(DIV - 1));
    wait_ticks(100);
    push("sw_100", 0, 0, 1, 0, 1, 0, 0);
    pop_cmp();
    pulse(P_RUN);
    ticks_seen = 0;
    idle(50 * DIV);
    push("sw_hold", 0, 0, 1, 0, 0, 0, 0);
    pop_cmp();
    check("sw_hold_ticks", 32'(ticks_seen), 32'd0);

    // watch full wrap
    pulse(P_CLR);
    push("sw_clear", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();
    mode = 2'b10;
    step();
    push("watch_enter", 0, 0, 0, 0, 1, 0, 0);
    pop_cmp();
    adjust(2'd2, 1'b0, 1'b1);
    adjust(2'd1, 1'b0, 1'b1);
    adjust(2'd0, 1'b0, 1'b1);
    push("watch_set", 23, 59, 59, 0, 1, 0, 0);
    pop_cmp();
    dones_seen = 0;
    wait_ticks(100);
    push("watch_wrap", 0, 0, 0, 0, 1, 0, 0);
    pop_cmp();
    check("watch_no_done", 32'(dones_seen), 32'd0);

    // adjust coincident with a tick
    w = 0;
    while (!tick_o && w < 3 * DIV) begin
      step();
      w++;
    end
    check("tick_found", 32'(tick_o), 32'd1);
    adjust(2'd0, 1'b1, 1'b0);
    push("adj_vs_tick", 0, 0, 1, 0, 1, 0, 0);
    pop_cmp();

    // countdown timer
    mode = 2'b01;
    step();
    push("tmr_enter", 0, 0, 1, 0, 0, 0, 0);
    pop_cmp();
    pulse(P_CLR);
    adjust(2'd0, 1'b1, 1'b0);
    adjust(2'd0, 1'b1, 1'b0);
    push("tmr_set", 0, 0, 2, 0, 0, 0, 0);
    pop_cmp();
    pulse(P_RUN);
    push("tmr_run", 0, 0, 2, 0, 1, 0, 0);
    pop_cmp();
    dones_seen = 0;
    wait_ticks(200);
    push("tmr_done", 0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
    ticks_seen = 0;
    idle(50 * DIV);
    push("tmr_after", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();
    check("tmr_done_once", 32'(dones_seen), 32'd1);
    check("tmr_after_ticks", 32'(ticks_seen), 32'd0);
    pulse(P_RUN);
    push("tmr_zero_run", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();

    // lap hold
    mode = 2'b00;
    step();
    pulse(P_RUN);
    wait_ticks(50);
    push("lap_pre", 0, 0, 0, 50, 1, 0, 0);
    pop_cmp();
    pulse(P_LAP);
    push("lap_on", 0, 0, 0, 50, 1, 1, 0);
    pop_cmp();
    wait_ticks(100);
    push("lap_hold", 0, 0, 0, 50, 1, 1, 0);
    pop_cmp();
    pulse(P_LAP);
    push("lap_off", 0, 0, 1, 50, 1, 0, 0);
    pop_cmp();

    // mode change mid-run, then simultaneous events in stopped timer
    wait_ticks(150);
    push("sw_3s", 0, 0, 3, 0, 1, 0, 0);
    pop_cmp();
    mode = 2'b01;
    step();
    push("mode_chg", 0, 0, 3, 0, 0, 0, 0);
    pop_cmp();
    adjust(2'd0, 1'b1, 1'b1);
    push("inc_dec", 0, 0, 3, 0, 0, 0, 0);
    pop_cmp();
    adjust(2'd0, 1'b1, 1'b0);
    push("tmr_inc", 0, 0, 4, 0, 0, 0, 0);
    pop_cmp();
    pulse(P_RUNCLR);
    push("clr_run", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();
    ticks_seen = 0;
    idle(3 * DIV);
    check("clr_run_ticks", 32'(ticks_seen), 32'd0);

    // reset mid-run with lap held
    mode = 2'b00;
    step();
    pulse(P_RUN);
    wait_ticks(500);
    pulse(P_LAP);
    push("pre_rst", 0, 0, 5, 0, 1, 1, 0);
    pop_cmp();
    rst = 1'b1;
    step();
    push("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();
    check("rst_tick", 32'(tick_o), 32'd0);
    rst = 1'b0;
    ticks_seen = 0;
    idle(5 * DIV);
    push("rst_idle", 0, 0, 0, 0, 0, 0, 0);
    pop_cmp();
    check("rst_idle_ticks", 32'(ticks_seen), 32'd0);
    pulse(P_RUN);
    wait_ticks(3);
    push("rst_restart", 0, 0, 0, 3, 1, 0, 0);
    pop_cmp();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
